// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and encodings for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

  // Arbiter FSM: wait for a requester, drive the address phase, wait for data.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  // Owner / round-robin encodings; bit position in the request vector matches.
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Transfer size codes carried on the bus.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin picker.
// req[0] = instruction port, req[1] = data port; 'last' is the previous winner.
module rr_arbiter_2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // A lone requester always wins; on a tie the port that did not win last time goes.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWNER_INST) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the IF fetch port and the MEM load/store port.
// One transaction in flight: grant in IDLE, address phase in ADDR, data phase in WAIT.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // instruction port
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  // data port
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  // shared bus
  output logic                  bus_req,
  output logic                  bus_wr,
  output logic [1:0]            bus_size,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_addr_ok,
  input  logic                  bus_data_ok,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic                rr_last_q, rr_last_d;
  logic                hold_wr_q, hold_wr_d;
  logic [1:0]          hold_size_q, hold_size_d;
  logic [STRB_W-1:0]   hold_wstrb_q, hold_wstrb_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;

  logic [1:0]          grant;
  logic                grant_cycle;
  logic                resp_cycle;

  rr_arbiter_2 u_rr (
    .req   ({data_req, inst_req}),
    .last  (rr_last_q),
    .grant (grant)
  );

  // A grant only happens from IDLE; a response is only accepted in WAIT.
  assign grant_cycle = (state_q == ARB_IDLE) && (grant != 2'b00) && !reset;
  assign resp_cycle  = (state_q == ARB_WAIT) && bus_data_ok && !reset;

  // State, ownership and hold register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_INST;
      rr_last_q    <= OWNER_INST;
      hold_wr_q    <= 1'b0;
      hold_size_q  <= 2'b00;
      hold_wstrb_q <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      hold_wr_q    <= hold_wr_d;
      hold_size_q  <= hold_size_d;
      hold_wstrb_q <= hold_wstrb_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
    end
  end

  // Next state plus latching of the winner's request fields on the grant cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    hold_wr_d    = hold_wr_q;
    hold_size_d  = hold_size_q;
    hold_wstrb_d = hold_wstrb_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_cycle) begin
          state_d   = ARB_ADDR;
          owner_d   = grant[1] ? OWNER_DATA : OWNER_INST;
          rr_last_d = grant[1] ? OWNER_DATA : OWNER_INST;
          if (grant[1]) begin
            hold_wr_d    = data_wr;
            hold_size_d  = data_size;
            hold_wstrb_d = data_wstrb;
            hold_addr_d  = data_addr;
            hold_wdata_d = data_wdata;
          end else begin
            // Fetches are always full-word reads.
            hold_wr_d    = 1'b0;
            hold_size_d  = SIZE_WORD;
            hold_wstrb_d = '0;
            hold_addr_d  = inst_addr;
            hold_wdata_d = '0;
          end
        end
      end
      ARB_ADDR: begin
        if (bus_addr_ok) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (bus_data_ok) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Bus drive and response routing; everything is forced low while reset is high.
  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'b00;
    bus_wstrb    = '0;
    bus_addr     = '0;
    bus_wdata    = '0;
    if (!reset) begin
      inst_addr_ok = grant_cycle && grant[0];
      data_addr_ok = grant_cycle && grant[1];
      bus_req      = (state_q == ARB_ADDR);
      bus_wr       = hold_wr_q;
      bus_size     = hold_size_q;
      bus_wstrb    = hold_wstrb_q;
      bus_addr     = hold_addr_q;
      bus_wdata    = hold_wdata_q;
      if (resp_cycle) begin
        if (owner_q == OWNER_DATA) begin
          data_data_ok = 1'b1;
          data_rdata   = bus_rdata;
        end else begin
          inst_data_ok = 1'b1;
          inst_rdata   = bus_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitration slot with both masters requesting: grant, addr phase, data phase.
  task automatic both_txn(input int idx, input logic exp_data, input logic [31:0] val);
    @(negedge clk);
    chk("rr_grant_data", 64'(data_addr_ok), 64'(exp_data));
    chk("rr_grant_inst", 64'(inst_addr_ok), 64'(!exp_data));
    tick();
    bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("rr_bus_req", 64'(bus_req), 64'd1);
    chk("rr_bus_addr", 64'(bus_addr), exp_data ? 64'h400 : 64'h1000);
    chk("rr_bus_wr", 64'(bus_wr), 64'(exp_data));
    chk("rr_bus_size", 64'(bus_size), 64'd2);
    chk("rr_bus_wstrb", 64'(bus_wstrb), exp_data ? 64'hF : 64'h0);
    tick();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = val;
    @(negedge clk);
    chk("rr_data_ok_d", 64'(data_data_ok), 64'(exp_data));
    chk("rr_data_ok_i", 64'(inst_data_ok), 64'(!exp_data));
    chk("rr_rdata_d", 64'(data_rdata), exp_data ? 64'(val) : 64'h0);
    chk("rr_rdata_i", 64'(inst_rdata), exp_data ? 64'h0 : 64'(val));
    chk("rr_no_grant_on_resp", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
    $display("txn %0d: owner=%s rdata=0x%08h", idx, exp_data ? "data" : "inst", val);
    tick();
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    tick(); tick();

    // Reset state: requests and stray responses must not reach any output.
    inst_req = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
    chk("rst_inst_data_ok", 64'(inst_data_ok), 64'd0);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    tick();
    reset = 1'b0; inst_req = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

    // T1: lw 0x100 from the data port alone.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h100;
    @(negedge clk);
    chk("t1_data_addr_ok", 64'(data_addr_ok), 64'd1);
    chk("t1_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
    chk("t1_bus_req_c1", 64'(bus_req), 64'd0);
    tick();
    data_req = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("t1_bus_req_c2", 64'(bus_req), 64'd1);
    chk("t1_bus_addr", 64'(bus_addr), 64'h100);
    chk("t1_bus_wr", 64'(bus_wr), 64'd0);
    chk("t1_bus_size", 64'(bus_size), 64'd2);
    chk("t1_addr_ok_once", 64'(data_addr_ok), 64'd0);
    tick();
    bus_addr_ok = 1'b0;
    @(negedge clk);
    chk("t1_bus_req_c3", 64'(bus_req), 64'd0);
    chk("t1_data_ok_c3", 64'(data_data_ok), 64'd0);
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_data_ok_c4", 64'(data_data_ok), 64'd1);
    chk("t1_data_rdata", 64'(data_rdata), 64'hDEAD_BEEF);
    chk("t1_inst_data_ok", 64'(inst_data_ok), 64'd0);
    chk("t1_inst_rdata", 64'(inst_rdata), 64'd0);
    $display("txn T1: lw 0x100 rdata=0x%08h", data_rdata);
    tick();
    bus_data_ok = 1'b0; bus_rdata = 32'h0;

    // T2/T3: reset restores rr_last=inst, then both masters request continuously.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1000;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b10; data_wstrb = 4'hF;
    data_addr = 32'h400; data_wdata = 32'hA5A5_A5A5;
    both_txn(0, 1'b1, 32'h1111_0000);
    both_txn(1, 1'b0, 32'h2222_0001);
    both_txn(2, 1'b1, 32'h3333_0002);
    both_txn(3, 1'b0, 32'h4444_0003);
    inst_req = 1'b0; data_req = 1'b0;

    // T4: sb 0x203 with the address phase stalled for 3 cycles.
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b00; data_wstrb = 4'b1000;
    data_addr = 32'h203; data_wdata = 32'h4400_0000;
    @(negedge clk);
    chk("t4_data_addr_ok", 64'(data_addr_ok), 64'd1);
    tick();
    data_req = 1'b0; inst_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_stall_bus_req", 64'(bus_req), 64'd1);
      chk("t4_stall_addr", 64'(bus_addr), 64'h203);
      chk("t4_stall_wstrb", 64'(bus_wstrb), 64'h8);
      chk("t4_stall_size", 64'(bus_size), 64'd0);
      chk("t4_stall_wr", 64'(bus_wr), 64'd1);
      chk("t4_stall_wdata", 64'(bus_wdata), 64'h4400_0000);
      chk("t4_stall_no_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
      tick();
    end
    bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("t4_bus_req_accept", 64'(bus_req), 64'd1);
    tick();
    bus_addr_ok = 1'b0; inst_req = 1'b0; bus_data_ok = 1'b1;
    @(negedge clk);
    chk("t4_data_ok", 64'(data_data_ok), 64'd1);
    chk("t4_inst_data_ok", 64'(inst_data_ok), 64'd0);
    $display("txn T4: sb 0x203 wstrb=0x8 done");
    tick();
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("t4_idle_no_grant", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
    tick();

    // T5: reset while waiting for data; the late response must be dropped.
    inst_req = 1'b1; inst_addr = 32'h2000;
    @(negedge clk);
    chk("t5_inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_bus_req", 64'(bus_req), 64'd0);
    tick();
    reset = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0055;
    @(negedge clk);
    chk("t5_inst_data_ok", 64'(inst_data_ok), 64'd0);
    chk("t5_data_data_ok", 64'(data_data_ok), 64'd0);
    chk("t5_inst_rdata", 64'(inst_rdata), 64'd0);
    $display("txn T5: reset in WAIT, late response dropped");
    tick();

    // T6: stray responses in IDLE and ADDR, stray addr_ok in WAIT/IDLE.
    @(negedge clk);
    chk("t6_idle_stray", 64'({inst_data_ok, data_data_ok}), 64'd0);
    tick();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'b10; data_addr = 32'h300;
    @(negedge clk);
    chk("t6_grant", 64'(data_addr_ok), 64'd1);
    chk("t6_grant_no_data_ok", 64'(data_data_ok), 64'd0);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    chk("t6_addr_stray_req", 64'(bus_req), 64'd1);
    chk("t6_addr_stray_ok", 64'(data_data_ok), 64'd0);
    tick();
    bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("t6_still_addr", 64'(bus_req), 64'd1);
    chk("t6_bus_addr", 64'(bus_addr), 64'h300);
    tick();
    @(negedge clk);
    chk("t6_wait_req", 64'(bus_req), 64'd0);
    chk("t6_wait_no_ok", 64'(data_data_ok), 64'd0);
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("t6_data_ok", 64'(data_data_ok), 64'd1);
    chk("t6_rdata", 64'(data_rdata), 64'h1234_5678);
    $display("txn T6: lw 0x300 rdata=0x%08h", data_rdata);
    tick();
    bus_data_ok = 1'b0; bus_rdata = 32'h0; bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("t6_idle_addr_ok_req", 64'(bus_req), 64'd0);
    tick();
    bus_addr_ok = 1'b0;
    @(negedge clk);
    chk("t6_idle_stays", 64'(bus_req), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
